axis_packet_stats: RTL
======================

// Module: axis_packet_stats
// PURPOSE
// - Parametrised AXI-Stream pass-through with full backpressure and traffic statistics.
// - Counts beats and TLAST-delimited packets, and tracks the longest packet seen.
// - Sits inline on any AXIS path to monitor it; data and TLAST pass unmodified.
// - Output is a registered 2-entry skid buffer, so the stream runs at full throughput.
// PARAMETERS
// - DW       default 128  TDATA width in bits.
// - CW       default 32   width of beat_count, packet_count and stall_count.
// - LW       default 16   width of cur_pkt_len and max_pkt_len.
// - SATURATE default 0    0: counters wrap modulo 2^width; 1: counters hold at all-ones.
// PORTS
// - clk             in   1   clock; all logic is rising-edge.
// - resetn          in   1   asynchronous, active-low reset.
// - stats_clear     in   1   synchronous clear pulse for the statistics.
// - axis_in_tdata   in   DW  input stream data.
// - axis_in_tvalid  in   1   input stream valid.
// - axis_in_tlast   in   1   input stream last beat of packet.
// - axis_in_tready  out  1   input stream ready; registered.
// - axis_out_tdata  out  DW  output stream data; registered.
// - axis_out_tvalid out  1   output stream valid; registered.
// - axis_out_tlast  out  1   output stream last beat; registered.
// - axis_out_tready in   1   output stream ready.
// - beat_count      out  CW  accepted output beats.
// - packet_count    out  CW  accepted output beats with TLAST set.
// - cur_pkt_len     out  LW  beats so far in the packet in flight.
// - max_pkt_len     out  LW  longest completed packet, in beats.
// - stall_count     out  CW  present only with AXIS_STATS_STALL_EN.
// BEHAVIOUR
// - Reset (async assert, sync release): every register and output is 0, including axis_in_tready.
//   - axis_in_tready rises on the first clk edge after resetn deasserts.
//   - resetn asserted mid-packet discards all buffered beats. The counters hold no partial state.
// - Handshakes: in_hs = in_tvalid & in_tready; out_hs = out_tvalid & out_tready.
// - Skid buffer FSM, with states EMPTY, ONE and FULL:
//   - EMPTY: in_hs loads the output register -> ONE.
//   - ONE, in_hs & !out_hs: the beat goes to the skid register -> FULL.
//   - ONE, !in_hs & out_hs: -> EMPTY.
//   - ONE, in_hs & out_hs: the output register reloads; stay in ONE.
//   - FULL, out_hs: the skid register moves to the output register -> ONE.
//   - axis_in_tready = (state != FULL), registered.
// - Latency and ordering:
//   - Latency in -> out is 1 cycle when the buffer is not stalled.
//   - Sustained throughput is 1 beat/cycle.
//   - Order is preserved. No beat is dropped or duplicated.
// - While out_tvalid & !out_tready, out_tdata and out_tlast are held stable.
// - Statistics update on out_hs only, with results visible the cycle after:
//   - beat_count += 1.
//   - Without TLAST: cur_pkt_len += 1.
//   - With TLAST: packet_count += 1; L = cur_pkt_len + 1; max_pkt_len = max(max_pkt_len, L); cur_pkt_len = 0.
// - Width rules:
//   - SATURATE=0: all counters wrap to 0 after all-ones.
//   - SATURATE=1: all counters stick at all-ones, and L saturates before the max compare.
// - stats_clear (priority over a same-cycle out_hs):
//   - beat_count, packet_count, max_pkt_len and stall_count go to 0; that cycle's increments are discarded.
//   - cur_pkt_len is NOT cleared, so the packet in flight is still measured correctly.
//   - Data flow is unaffected by stats_clear.
// CONFIGURATION
// - AXIS_STATS_STALL_EN defined:
//   - stall_count port exists.
//   - It increments every cycle out_tvalid & !out_tready, obeys SATURATE, and is cleared by reset and stats_clear.
// - AXIS_STATS_STALL_EN undefined: stall_count port and its logic are absent; all else is identical.
// TESTING
// - Reset, then 3 packets of lengths 1/4/2 with out_tready=1:
//   -> beat_count=7, packet_count=3, max_pkt_len=4, cur_pkt_len=0, 1-cycle latency.
// - out_tready=0 for 5 cycles during a stream:
//   -> in_tready drops after 2 beats buffered; data held stable.
//   -> On release, all beats emerge in order with none lost.
//   -> stall_count=5 when AXIS_STATS_STALL_EN is defined.
// - Random tvalid/tready over 10k beats, compared against a scoreboard
//   -> identical data sequence; beat_count and packet_count match the model.
// - stats_clear in the same cycle as an out_hs, in the middle of a 6-beat packet (3 beats before, 3 after)
//   -> beat_count=3 after the packet completes, packet_count=1, max_pkt_len=6.
// - CW=4, SATURATE=0 vs 1, 20 single-beat packets
//   -> wrap gives packet_count=4; saturate gives packet_count=15.
// - resetn asserted mid-packet with the buffer FULL
//   -> outputs 0 immediately; the next packet after release is counted from length 1.

Source files
------------

// File: rtl/axis_packet_stats.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_stats
// Purpose  : AXI-Stream pass-through monitor. A registered 2-entry skid
//            buffer carries the stream at full throughput with backpressure.
//            Beats, TLAST-delimited packets, the current packet length and the
//            longest completed packet are counted on output handshakes.
// Ports    : clk, resetn (async active-low), stats_clear (sync clear pulse)
//            axis_in_*   : upstream slave side (tready registered)
//            axis_out_*  : downstream master side (all outputs registered)
//            beat_count, packet_count, cur_pkt_len, max_pkt_len : statistics
//            stall_count : cycles with out_tvalid & !out_tready
// Options  : AXIS_STATS_STALL_EN - when defined, adds stall_count and its
//            counter; when undefined, both are absent.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_stats #(
  parameter int DW       = 128,
  parameter int CW       = 32,
  parameter int LW       = 16,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stats_clear,
  input  logic [DW-1:0] axis_in_tdata,
  input  logic          axis_in_tvalid,
  input  logic          axis_in_tlast,
  output logic          axis_in_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  output logic          axis_out_tlast,
  input  logic          axis_out_tready,
  output logic [CW-1:0] beat_count,
  output logic [CW-1:0] packet_count,
  output logic [LW-1:0] cur_pkt_len,
  output logic [LW-1:0] max_pkt_len
`ifdef AXIS_STATS_STALL_EN
  ,
  output logic [CW-1:0] stall_count
`endif
);

  localparam bit c_SAT = (SATURATE != 0);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_load_out;
  logic            w_load_skid;
  logic            w_skid_to_out;

  logic [DW-1:0]   r_out_data;
  logic            r_out_last;
  logic            r_out_valid;
  logic [DW-1:0]   r_skid_data;
  logic            r_skid_last;
  logic            r_in_ready;

  logic            w_in_hs;
  logic            w_out_hs;

  logic [CW-1:0]   r_beat_count;
  logic [CW-1:0]   r_packet_count;
  logic [LW-1:0]   r_cur_pkt_len;
  logic [LW-1:0]   r_max_pkt_len;
  logic [CW-1:0]   w_beat_inc;
  logic [CW-1:0]   w_packet_inc;
  logic [LW-1:0]   w_pkt_len;
  logic [LW-1:0]   w_max_nxt;

  assign w_in_hs  = axis_in_tvalid & r_in_ready;
  assign w_out_hs = r_out_valid & axis_out_tready;

  // --------------------------------------------------------------------------
  // Skid buffer control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_hs) begin
          w_next_state = S_ONE;
          w_load_out   = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_hs && !w_out_hs) begin
          w_next_state = S_FULL;
          w_load_skid  = 1'b1;
        end else if (!w_in_hs && w_out_hs) begin
          w_next_state = S_EMPTY;
        end else if (w_in_hs && w_out_hs) begin
          w_load_out   = 1'b1;
        end
      end
      S_FULL: begin
        // tready is low here, so no new beat can arrive in this state
        if (w_out_hs) begin
          w_next_state  = S_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
      end
    endcase
  end

  // Valid and ready are registered from the next state so both are plain
  // flops at the ports without adding a cycle of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_out_data <= axis_in_tdata;
        r_out_last <= axis_in_tlast;
      end else if (w_skid_to_out) begin
        r_out_data <= r_skid_data;
        r_out_last <= r_skid_last;
      end
      if (w_load_skid) begin
        r_skid_data <= axis_in_tdata;
        r_skid_last <= axis_in_tlast;
      end
      r_out_valid <= (w_next_state != S_EMPTY);
      r_in_ready  <= (w_next_state != S_FULL);
    end
  end

  assign axis_in_tready  = r_in_ready;
  assign axis_out_tdata  = r_out_data;
  assign axis_out_tlast  = r_out_last;
  assign axis_out_tvalid = r_out_valid;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  assign w_beat_inc   = (c_SAT && (&r_beat_count))   ? r_beat_count   : r_beat_count + CW'(1);
  assign w_packet_inc = (c_SAT && (&r_packet_count)) ? r_packet_count : r_packet_count + CW'(1);
  // Length including the current beat; also the next cur_pkt_len value
  assign w_pkt_len    = (c_SAT && (&r_cur_pkt_len))  ? r_cur_pkt_len  : r_cur_pkt_len + LW'(1);
  assign w_max_nxt    = (w_pkt_len > r_max_pkt_len)  ? w_pkt_len      : r_max_pkt_len;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_count   <= '0;
      r_packet_count <= '0;
      r_cur_pkt_len  <= '0;
      r_max_pkt_len  <= '0;
    end else begin
      // cur_pkt_len ignores stats_clear so the packet in flight keeps its length
      if (w_out_hs) begin
        r_cur_pkt_len <= r_out_last ? '0 : w_pkt_len;
      end
      if (stats_clear) begin
        r_beat_count   <= '0;
        r_packet_count <= '0;
        r_max_pkt_len  <= '0;
      end else if (w_out_hs) begin
        r_beat_count <= w_beat_inc;
        if (r_out_last) begin
          r_packet_count <= w_packet_inc;
          r_max_pkt_len  <= w_max_nxt;
        end
      end
    end
  end

  assign beat_count   = r_beat_count;
  assign packet_count = r_packet_count;
  assign cur_pkt_len  = r_cur_pkt_len;
  assign max_pkt_len  = r_max_pkt_len;

`ifdef AXIS_STATS_STALL_EN
  logic [CW-1:0] r_stall_count;
  logic [CW-1:0] w_stall_inc;

  assign w_stall_inc = (c_SAT && (&r_stall_count)) ? r_stall_count : r_stall_count + CW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= '0;
    end else if (stats_clear) begin
      r_stall_count <= '0;
    end else if (r_out_valid && !axis_out_tready) begin
      r_stall_count <= w_stall_inc;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
